// File: rtl/operand_forward_stage_if.sv
// operand_forward_stage_if: upstream operand request channel and downstream collected-operand channel
interface operand_forward_stage_if #(
  parameter int NPORTS = 6,
  parameter int XLEN   = 32,
  parameter int REGW   = 6
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_pc;
  logic [NPORTS-1:0]      in_use;
  logic [NPORTS*REGW-1:0] in_rs;
  logic [NPORTS*XLEN-1:0] rf_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [NPORTS*XLEN-1:0] out_data;
  logic [NPORTS-1:0]      out_fwd;
  modport master (
    output in_valid, in_pc, in_use, in_rs, rf_data, out_ready,
    input  in_ready, out_valid, out_pc, out_data, out_fwd
  );
  modport slave (
    input  in_valid, in_pc, in_use, in_rs, rf_data, out_ready,
    output in_ready, out_valid, out_pc, out_data, out_fwd
  );
endinterface

// File: rtl/operand_forward_stage.sv
// operand_forward_stage: resolves source operands from the RF or youngest in-flight result, stalls on unready results
module operand_forward_stage #(
  parameter int NPORTS = 6,
  parameter int NSRC   = 6,
  parameter int XLEN   = 32,
  parameter int REGW   = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  operand_forward_stage_if.slave bus,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*REGW-1:0]   src_rd,
  input  logic [NSRC-1:0]        src_rdy,
  input  logic [NSRC*XLEN-1:0]   src_data,
  input  logic                   flush,
  output logic [15:0]            stall_cnt
);
  logic [NPORTS*XLEN-1:0] sel_data;
  logic [NPORTS-1:0]      sel_fwd, port_haz;
  logic                   hazard, accept;
  logic                   out_valid_q;
  logic [31:0]            out_pc_q;
  logic [NPORTS*XLEN-1:0] out_data_q;
  logic [NPORTS-1:0]      out_fwd_q;
  // Sources are scanned oldest first so the youngest match overwrites the rest.
  always_comb begin
    sel_data = '0;
    sel_fwd  = '0;
    port_haz = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (bus.in_rs[p*REGW +: REGW] != '0) begin
        sel_data[p*XLEN +: XLEN] = bus.rf_data[p*XLEN +: XLEN];
        for (int s = NSRC-1; s >= 0; s--) begin
          if (src_valid[s] && src_rd[s*REGW +: REGW] == bus.in_rs[p*REGW +: REGW]) begin
            sel_data[p*XLEN +: XLEN] = src_data[s*XLEN +: XLEN];
            sel_fwd[p]  = 1'b1;
            port_haz[p] = bus.in_use[p] && !src_rdy[s];
          end
        end
      end
    end
  end
  assign hazard       = |port_haz;
  assign bus.in_ready = !flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_fwd   = out_fwd_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_data_q  <= '0;
      out_fwd_q   <= '0;
      stall_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= bus.in_pc;
        out_data_q  <= sel_data;
        out_fwd_q   <= sel_fwd;
      end else if (flush || bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bus.in_valid && hazard && !flush && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_operand_forward_stage.sv
// tb_operand_forward_stage: scoreboard bench with a behavioural forwarding model and randomized traffic
module tb_operand_forward_stage;
  localparam int NP = 6;
  localparam int NS = 6;
  localparam int XL = 32;
  localparam int RW = 6;

  typedef struct {
    logic [31:0]      pc;
    logic [NP*XL-1:0] d;
    logic [NP-1:0]    f;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NS-1:0]    src_valid, src_rdy;
  logic [NS*RW-1:0] src_rd;
  logic [NS*XL-1:0] src_data;
  logic             flush;
  logic [15:0]      stall_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  logic [15:0] exp_stall = '0;

  operand_forward_stage_if #(.NPORTS(NP), .XLEN(XL), .REGW(RW)) bus ();

  operand_forward_stage #(.NPORTS(NP), .NSRC(NS), .XLEN(XL), .REGW(RW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .src_valid(src_valid), .src_rd(src_rd), .src_rdy(src_rdy), .src_data(src_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: first matching source in age order wins, register 0 reads as zero.
  task automatic model(output logic [NP*XL-1:0] d, output logic [NP-1:0] f, output logic hz);
    d = '0; f = '0; hz = 1'b0;
    for (int p = 0; p < NP; p++) begin
      logic [RW-1:0] rs;
      int w;
      rs = bus.in_rs[p*RW +: RW];
      w = -1;
      for (int s = 0; s < NS; s++)
        if (w < 0 && src_valid[s] && src_rd[s*RW +: RW] == rs) w = s;
      if (rs == 0) d[p*XL +: XL] = '0;
      else if (w >= 0) begin
        d[p*XL +: XL] = src_data[w*XL +: XL];
        f[p] = 1'b1;
        if (bus.in_use[p] && !src_rdy[w]) hz = 1'b1;
      end else d[p*XL +: XL] = bus.rf_data[p*XL +: XL];
    end
  endtask

  // Called at posedge+1 with inputs settled; returns at the next posedge+1.
  task automatic step();
    logic [NP*XL-1:0] d;
    logic [NP-1:0]    f;
    logic             hz, rdy, acc;
    exp_t             e;
    #1;
    model(d, f, hz);
    rdy = !flush && !hz && (q.size() == 0 || bus.out_ready);
    chk("in_ready", {255'd0, bus.in_ready}, {255'd0, rdy});
    chk("stall_cnt", {240'd0, stall_cnt}, {240'd0, exp_stall});
    acc = bus.in_valid && rdy;
    if (bus.in_valid && hz && !flush && exp_stall < 16'hFFFF) exp_stall = exp_stall + 1;
    e.pc = bus.in_pc; e.d = d; e.f = f;
    @(posedge clk);
    if (flush) q.delete();
    if (acc) q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      chk("out_valid", {255'd0, bus.out_valid}, {255'd0, q.size() != 0});
      if (bus.out_valid && q.size() != 0) begin
        chk("out_pc", {224'd0, bus.out_pc}, {224'd0, q[0].pc});
        chk("out_data", {64'd0, bus.out_data}, {64'd0, q[0].d});
        chk("out_fwd", {250'd0, bus.out_fwd}, {250'd0, q[0].f});
        if (bus.out_ready && !flush) void'(q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_pc = '0; bus.in_use = '0; bus.in_rs = '0; bus.rf_data = '0;
    bus.out_ready = 1; src_valid = '0; src_rd = '0; src_rdy = '0; src_data = '0; flush = 0;
  endtask

  function automatic logic [RW-1:0] pick_reg();
    logic [RW-1:0] r;
    r = RW'($urandom_range(0, 5));
    if ($urandom_range(0, 3) == 0) r[RW-1] = 1'b1;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, {255'd0, bus.out_valid}, 256'd0);
    chk({tag, "_pc"}, {224'd0, bus.out_pc}, 256'd0);
    chk({tag, "_data"}, {64'd0, bus.out_data}, 256'd0);
    chk({tag, "_fwd"}, {250'd0, bus.out_fwd}, 256'd0);
    chk({tag, "_stall"}, {240'd0, stall_cnt}, 256'd0);
  endtask

  initial begin
    logic [15:0] s0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rstn = 1;
    step();

    // RF path, no sources
    bus.in_valid = 1; bus.in_pc = 32'h100; bus.in_use = '1;
    for (int p = 0; p < NP; p++) begin
      bus.in_rs[p*RW +: RW] = RW'(p + 1);
      bus.rf_data[p*XL +: XL] = XL'(p * 16);
    end
    step();
    chk("rf_p1", {224'd0, bus.out_data[1*XL +: XL]}, 256'h10);
    chk("rf_fwd", {250'd0, bus.out_fwd}, 256'd0);

    // youngest of two ready matches wins
    bus.in_pc = 32'h104; bus.in_rs[0 +: RW] = 6'd5;
    src_valid = 6'b000101; src_rdy = 6'b000101;
    src_rd[0*RW +: RW] = 6'd5; src_rd[2*RW +: RW] = 6'd5;
    src_data[0*XL +: XL] = 32'hAAAA; src_data[2*XL +: XL] = 32'hBBBB;
    step();
    chk("young_data", {224'd0, bus.out_data[0 +: XL]}, 256'hAAAA);
    chk("young_fwd", {255'd0, bus.out_fwd[0]}, 256'd1);

    // register 0 never forwards
    bus.in_pc = 32'h108; bus.in_rs[0 +: RW] = '0;
    src_valid = 6'b000001; src_rdy = 6'b000000;
    src_rd[0 +: RW] = '0; src_data[0 +: XL] = 32'hFFFF;
    step();
    chk("zero_data", {224'd0, bus.out_data[0 +: XL]}, 256'd0);
    chk("zero_fwd", {255'd0, bus.out_fwd[0]}, 256'd0);

    // load-use stall of three cycles, then accept without a bubble
    idle_inputs();
    bus.in_valid = 1; bus.in_pc = 32'h200; bus.in_use = 6'b000100;
    for (int p = 0; p < NP; p++) bus.in_rs[p*RW +: RW] = RW'(p + 8);
    bus.in_rs[2*RW +: RW] = 6'd7;
    src_valid = 6'b000010; src_rd[1*RW +: RW] = 6'd7; src_data[1*XL +: XL] = 32'h7777;
    s0 = stall_cnt;
    repeat (3) step();
    src_rdy = 6'b000010;
    step();
    chk("lu_stalls", {240'd0, stall_cnt - s0}, 256'd3);
    chk("lu_data", {224'd0, bus.out_data[2*XL +: XL]}, 256'h7777);
    bus.in_use = 6'b000000; src_rdy = '0; bus.in_pc = 32'h204;
    s0 = stall_cnt;
    step();
    chk("lu_unused", {240'd0, stall_cnt - s0}, 256'd0);

    // backpressure then back-to-back drain
    bus.out_ready = 0; bus.in_pc = 32'h300;
    repeat (4) step();
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin bus.in_pc = 32'h304 + 4 * i; step(); end

    // flush drops the held output and blocks capture
    bus.out_ready = 0; bus.in_pc = 32'h400;
    step();
    flush = 1; bus.in_pc = 32'h404;
    step();
    chk("flush_clear", {255'd0, bus.out_valid}, 256'd0);
    flush = 0;
    step();
    chk("flush_after", {224'd0, bus.out_pc}, 256'h404);
    bus.out_ready = 1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_pc = $urandom;
      bus.in_use = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        bus.in_rs[p*RW +: RW] = pick_reg();
        bus.rf_data[p*XL +: XL] = $urandom;
      end
      for (int s = 0; s < NS; s++) begin
        src_valid[s] = ($urandom_range(0, 2) == 0);
        src_rdy[s] = ($urandom_range(0, 9) < 7);
        src_rd[s*RW +: RW] = pick_reg();
        src_data[s*XL +: XL] = $urandom;
      end
      flush = ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // asynchronous reset mid-transfer
    idle_inputs();
    bus.in_valid = 1; bus.in_pc = 32'h500; bus.out_ready = 0;
    step();
    rstn = 0;
    #1;
    check_reset("mid_rst");
    q.delete();
    exp_stall = '0;
    @(posedge clk);
    #1;
    rstn = 1;
    bus.out_ready = 1;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_forward_stage.md
# operand_forward_stage

Parametrised register-operand collection stage between decode and execute. It resolves each source operand from the register file or from the youngest matching in-flight pipeline result, and stalls the upstream when that result is not yet available. It registers the collected operands behind a valid/ready handshake. It generalises the fixed six-port, fixed seven-way forwarding mux to N ports and S sources. Forward-select generation and load-use hazard detection happen internally instead of being supplied from outside.

## Interface
Parameters:
- NPORTS, 6, number of operand read ports
- NSRC, 6, number of bypass sources; index 0 = youngest (E), NSRC-1 = oldest
- XLEN, 32, data width
- REGW, 6, register index width (bit REGW-1 selects the FP/vector bank; index 0 is hard zero)

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  32  instruction PC
- in_use  in  NPORTS  per-port operand-needed mask
- in_rs  in  NPORTS*REGW  port p index at [p*REGW +: REGW]
- rf_data  in  NPORTS*XLEN  register-file read data for in_rs
- src_valid  in  NSRC  source s holds a writing instruction
- src_rd  in  NSRC*REGW  destination index of source s
- src_rdy  in  NSRC  source s result data is valid this cycle
- src_data  in  NSRC*XLEN  result data of source s
- flush  in  1  discard the held output and block capture
- out_valid  out  1  collected operands valid
- out_ready  in  1  downstream accepts
- out_pc  out  32  registered PC
- out_data  out  NPORTS*XLEN  registered operands
- out_fwd  out  NPORTS  port p was bypassed (not taken from the RF)
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Match per port p and source s: src_valid[s] && src_rd[s]==in_rs[p] && in_rs[p]!=0.
- Winner is the lowest matching s. Older matches are ignored even when their data is ready.
- Data per port:
  - in_rs[p]==0 gives 0.
  - If a winner exists, data is src_data[winner] and fwd=1.
  - Otherwise data is rf_data[p] and fwd=0.
- hazard = OR over p of (in_use[p] && winner exists && !src_rdy[winner]). Unused ports never cause a hazard, but their data and fwd are still captured.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Capture (accept) = in_valid && in_ready. On capture, out_pc, out_data and out_fwd load and out_valid is set to 1.
- Without capture:
  - if out_valid && out_ready, out_valid goes to 0 and the data registers hold.
  - otherwise everything holds. out_* stay stable while out_valid && !out_ready.
- flush clears out_valid on the next edge. Flush takes priority over capture and over a held output.
- stall_cnt increments on every cycle with in_valid && hazard && !flush, and saturates at 0xFFFF.

## Timing
- Reset (rstn=0, asynchronous): out_valid=0, out_pc=0, out_data=0, out_fwd=0, stall_cnt=0.
- in_ready is combinational from the current inputs. It is valid during reset as !flush && !hazard.
- Latency is 1 cycle from the accept edge to out_valid=1. Throughput is 1 per cycle when out_ready is held at 1.
- Hazard resolution: a stall lasts until the cycle the winner has src_rdy=1 or its match disappears. The accept happens in that same cycle with no bubble.
- A simultaneous accept and downstream take in the same cycle keeps out_valid=1 with the new data.
- Reset asserted mid-stall or mid-transfer forces the reset values immediately. Any instruction in flight is lost.

## Test plan
- Reset release, NPORTS=6, no sources valid; in_rs={1..6}, rf_data=p*0x10 -> one cycle after accept, out_data[p]=p*0x10, out_fwd=0, out_valid=1.
- Sources 0 and 2 both valid with rd=5, both rdy, data 0xAAAA / 0xBBBB; port0 rs=5 -> out_data[0]=0xAAAA, out_fwd[0]=1.
- Port0 rs=0 and source 0 rd=0 data 0xFFFF -> out_data[0]=0, out_fwd[0]=0, no stall.
- Load-use: source 1 rd=7 with src_rdy=0 for 3 cycles, port2 uses 7 -> in_ready=0 for 3 cycles and stall_cnt=3. Accept occurs on the 4th cycle with src_data[1]. Repeat with in_use[2]=0 -> no stall.
- Backpressure: out_ready=0 with out_valid=1 for 4 cycles while in_valid=1 -> out_* stable and in_ready=0. out_ready=1 then gives back-to-back transfers.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and no capture. Flush deasserted -> the pending instruction is accepted.
